// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: turns a cmd/rsp handshake interface
// into one AXI-Lite read or write transaction at a time.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                r_state, w_state;
    logic                  r_cmd_ready, w_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
    logic                  r_awvalid, w_awvalid;
    logic                  r_wvalid, w_wvalid;
    logic                  r_bready, w_bready;
    logic                  r_arvalid, w_arvalid;
    logic                  r_rready, w_rready;
    logic                  r_aw_done, w_aw_done;
    logic                  r_w_done, w_w_done;
    logic                  r_rsp_valid, w_rsp_valid;
    logic                  r_rsp_write, w_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
    logic [1:0]            r_rsp_resp, w_rsp_resp;
    logic                  w_aw_hs, w_w_hs;

    assign w_aw_hs = r_awvalid & AWREADY;
    assign w_w_hs  = r_wvalid & WREADY;

    // State register and every registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_resp  <= 2'b00;
        end else begin
            r_state     <= w_state;
            r_cmd_ready <= w_cmd_ready;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_aw_done   <= w_aw_done;
            r_w_done    <= w_w_done;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_write <= w_rsp_write;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_resp  <= w_rsp_resp;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state     = r_state;
        w_cmd_ready = r_cmd_ready;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_aw_done   = r_aw_done;
        w_w_done    = r_w_done;
        w_rsp_valid = r_rsp_valid;
        w_rsp_write = r_rsp_write;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_resp  = r_rsp_resp;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_addr      = cmd_addr;
                    w_wdata     = cmd_wdata;
                    w_cmd_ready = 1'b0;
                    if (cmd_write) begin
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_done = 1'b0;
                        w_w_done  = 1'b0;
                        w_state   = S_WR_REQ;
                    end else begin
                        w_arvalid = 1'b1;
                        w_state   = S_RD_REQ;
                    end
                end else begin
                    // Also raises cmd_ready on the first cycle after reset
                    w_cmd_ready = 1'b1;
                end
            end

            S_WR_REQ: begin
                w_aw_done = r_aw_done | w_aw_hs;
                w_w_done  = r_w_done | w_w_hs;
                if (w_aw_hs) begin
                    w_awvalid = 1'b0;
                end else begin
                    w_awvalid = r_awvalid;
                end
                if (w_w_hs) begin
                    w_wvalid = 1'b0;
                end else begin
                    w_wvalid = r_wvalid;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready = 1'b1;
                    w_state  = S_WR_RESP;
                end else begin
                    w_bready = 1'b0;
                end
            end

            S_WR_RESP: begin
                if (BVALID && r_bready) begin
                    w_rsp_resp  = BRESP;
                    w_rsp_rdata = {DATA_WIDTH{1'b0}};
                    w_rsp_write = 1'b1;
                    w_bready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_state     = S_RSP;
                end else begin
                    w_bready = 1'b1;
                end
            end

            S_RD_REQ: begin
                if (r_arvalid && ARREADY) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = S_RD_RESP;
                end else begin
                    w_arvalid = 1'b1;
                end
            end

            S_RD_RESP: begin
                if (RVALID && r_rready) begin
                    w_rsp_rdata = RDATA;
                    w_rsp_resp  = RRESP;
                    w_rready    = 1'b0;
                    w_rsp_write = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_state     = S_RSP;
                end else begin
                    w_rready = 1'b1;
                end
            end

            S_RSP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = S_IDLE;
                end else begin
                    w_rsp_valid = 1'b1;
                end
            end

            default: begin
                // Illegal encoding: drop all handshakes and fall back to idle
                w_state     = S_IDLE;
                w_cmd_ready = 1'b0;
                w_awvalid   = 1'b0;
                w_wvalid    = 1'b0;
                w_bready    = 1'b0;
                w_arvalid   = 1'b0;
                w_rready    = 1'b0;
                w_rsp_valid = 1'b0;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign AWADDR    = r_addr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_addr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small register-slave model
// whose READY timing and read response can be steered per test.
module tb_axi_lite_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model knobs and state
    logic [31:0] mem [16];
    int          w_delay = 0;
    int          w_wait  = 0;
    bit          force_r = 1'b0;
    logic [31:0] force_rdata = 32'd0;
    logic [1:0]  force_rresp = 2'b00;
    bit          aw_got, w_got;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata;
    logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    logic [3:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;

    // Slave acts on the falling edge; p_* hold what the DUT showed at the last rising edge
    always @(negedge clk) begin
        if (reset) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
            BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'd0;
            aw_got = 1'b0; w_got = 1'b0; w_wait = 0;
            p_awvalid = 1'b0; p_wvalid = 1'b0; p_bready = 1'b0; p_arvalid = 1'b0; p_rready = 1'b0;
            p_awaddr = 4'd0; p_araddr = 4'd0; p_wdata = 32'd0;
        end else begin
            hs_aw = p_awvalid && AWREADY;
            hs_w  = p_wvalid && WREADY;
            hs_b  = BVALID && p_bready;
            hs_ar = p_arvalid && ARREADY;
            hs_r  = RVALID && p_rready;
            if (hs_aw) begin
                chk("awvalid_drop", 32'(AWVALID), 32'd0);
                s_awaddr = p_awaddr; aw_got = 1'b1; AWREADY = 1'b0; w_wait = 0;
            end
            if (hs_w) begin
                chk("wvalid_drop", 32'(WVALID), 32'd0);
                s_wdata = p_wdata; w_got = 1'b1; WREADY = 1'b0;
            end
            if (hs_b) begin
                chk("bready_drop", 32'(BREADY), 32'd0);
                BVALID = 1'b0;
            end
            if (hs_r) begin
                chk("rready_drop", 32'(RREADY), 32'd0);
                RVALID = 1'b0;
            end
            if (hs_ar) begin
                chk("arvalid_drop", 32'(ARVALID), 32'd0);
                ARREADY = 1'b0;
                RVALID  = 1'b1;
                RDATA   = force_r ? force_rdata : mem[p_araddr];
                RRESP   = force_r ? force_rresp : 2'b00;
            end
            if (aw_got && w_got) begin
                mem[s_awaddr] = s_wdata;
                BVALID = 1'b1; BRESP = 2'b00;
                aw_got = 1'b0; w_got = 1'b0;
            end
            if (aw_got && !w_got) w_wait++;
            if (AWVALID && !AWREADY && !aw_got) AWREADY = 1'b1;
            if (WVALID && !WREADY && !w_got && (w_delay == 0 || (aw_got && w_wait >= w_delay)))
                WREADY = 1'b1;
            if (ARVALID && !ARREADY) ARREADY = 1'b1;
            p_awvalid = AWVALID; p_wvalid = WVALID; p_bready = BREADY;
            p_arvalid = ARVALID; p_rready = RREADY;
            p_awaddr = AWADDR; p_araddr = ARADDR; p_wdata = WDATA;
        end
    end

    bit saw_split = 1'b0;

    // Issue one command from a falling edge, watch the bus, collect and retire the response
    task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic [1:0] rs, output logic rw);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (wr) chk("aw_w_valid_up", 32'({AWVALID, WVALID}), 32'd3);
        else    chk("arvalid_up", 32'(ARVALID), 32'd1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            if (AWVALID) chk("awaddr_stable", 32'(AWADDR), 32'(a));
            if (WVALID)  chk("wdata_stable", WDATA, d);
            if (ARVALID) chk("araddr_stable", 32'(ARADDR), 32'(a));
            if (!AWVALID && WVALID) saw_split = 1'b1;
            if (BREADY)  chk("bready_after_w", 32'(WVALID), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rw;
    int          n;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0;
        cmd_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write then read back through the slave model
        run_cmd(1'b1, 4'h4, 32'hDEADBEEF, rd, rs, rw);
        chk("wr_rsp_write", 32'(rw), 32'd1);
        chk("wr_rsp_resp", 32'(rs), 32'd0);
        chk("wr_rsp_rdata", rd, 32'd0);
        chk("mem4_written", mem[4], 32'hDEADBEEF);
        run_cmd(1'b0, 4'h4, 32'd0, rd, rs, rw);
        chk("rd_rsp_rdata", rd, 32'hDEADBEEF);
        chk("rd_rsp_resp", 32'(rs), 32'd0);
        chk("rd_rsp_write", 32'(rw), 32'd0);

        // W accepted several cycles after AW
        w_delay = 3; saw_split = 1'b0;
        run_cmd(1'b1, 4'h8, 32'hA5A50001, rd, rs, rw);
        chk("aw_retired_before_w", 32'(saw_split), 32'd1);
        chk("slow_w_rsp_write", 32'(rw), 32'd1);
        chk("mem8_written", mem[8], 32'hA5A50001);
        w_delay = 0;

        // Response back-pressure with a second command already waiting
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_hold", 32'(rsp_valid), 32'd1);
            chk("bp_rdata_hold", rsp_rdata, 32'hA5A50001);
            chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("bp_not_yet_issued", 32'(ARVALID), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_issued", 32'(ARVALID), 32'd1);
        chk("bp_second_araddr", 32'(ARADDR), 32'h4);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_second_rdata", rsp_rdata, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Error response passed through
        force_r = 1'b1; force_rdata = 32'h12345678; force_rresp = 2'b10;
        run_cmd(1'b0, 4'h3, 32'd0, rd, rs, rw);
        chk("slverr_rresp", 32'(rs), 32'h2);
        chk("slverr_rdata", rd, 32'h12345678);
        force_r = 1'b0;

        // Reset in the middle of a write request
        w_delay = 60;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h0BADF00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_wr_valids_up", 32'({AWVALID, WVALID}), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_awvalid", 32'(AWVALID), 32'd0);
        chk("mid_rst_wvalid", 32'(WVALID), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; w_delay = 0;
        @(negedge clk);
        chk("post_mid_rst_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b0, 4'h4, 32'd0, rd, rs, rw);
        chk("post_rst_read", rd, 32'hDEADBEEF);
        chk("post_rst_resp", 32'(rs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
